// File: rtl/yuv422_pack.sv
// yuv422_pack: frame-aware 4:2:2 packer that interleaves u/v with luma into a
// show-ahead output FIFO with sticky overflow and odd-frame status flags.
module yuv422_pack #(
  parameter int                     PIXEL_WIDTH       = 8,
  parameter int                     DTYPE_WIDTH       = 5,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 'h01,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 'h02,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 'h04,
  parameter int                     FIFO_DEPTH        = 16
) (
  input  logic                           if_clk,
  input  logic                           resetb,
  input  logic                           enable,
  input  logic                           dvi,
  input  logic [DTYPE_WIDTH-1:0]         dtypei,
  input  logic [PIXEL_WIDTH-1:0]         y,
  input  logic [PIXEL_WIDTH-1:0]         u,
  input  logic [PIXEL_WIDTH-1:0]         v,
  output logic [2*PIXEL_WIDTH-1:0]       datao,
  output logic                           sofo,
  output logic                           dvo,
  input  logic                           rdyi,
  output logic [$clog2(FIFO_DEPTH):0]    level,
  output logic                           overflow,
  output logic                           odd_frame,
  input  logic                           clear_status
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic phase, phase_n, sof_pending, sof_n, attempt, frame_odd;
  logic fs, fe, px, full, push, pop;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [2*PIXEL_WIDTH:0] mem [FIFO_DEPTH];
  logic [2*PIXEL_WIDTH:0] head;
  assign fs = dvi && dtypei == DTYPE_FRAME_START;
  assign fe = dvi && dtypei == DTYPE_FRAME_END;
  assign px = dvi && dtypei == DTYPE_PIXEL;
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    sof_n     = sof_pending;
    attempt   = 1'b0;
    frame_odd = 1'b0;
    if (state == IDLE) begin
      if (enable && fs) begin
        state_n = ACTIVE;
        phase_n = 1'b0;
        sof_n   = 1'b1;
      end
    end else begin
      frame_odd = fe && phase;
      if (!enable || fe) state_n = IDLE;
      else if (fs) begin
        phase_n = 1'b0;
        sof_n   = 1'b1;
      end else if (px) begin
        attempt = 1'b1;
        phase_n = !phase;
        sof_n   = 1'b0;
      end
    end
  end
  // full is judged on the pre-pop occupancy, so a push into a full FIFO drops
  // even when a word leaves in the same cycle
  assign level = wr_ptr - rd_ptr;
  assign full  = level == (AW+1)'(FIFO_DEPTH);
  assign dvo   = level != '0;
  assign push  = attempt && !full;
  assign pop   = dvo && rdyi;
  assign head  = mem[rd_ptr[AW-1:0]];
  assign datao = dvo ? head[2*PIXEL_WIDTH-1:0] : '0;
  assign sofo  = dvo && head[2*PIXEL_WIDTH];
  always_ff @(posedge if_clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      phase       <= 1'b0;
      sof_pending <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      odd_frame   <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      sof_pending <= sof_n;
      wr_ptr      <= wr_ptr + (AW+1)'(push);
      rd_ptr      <= rd_ptr + (AW+1)'(pop);
      overflow    <= (attempt && full) || (overflow && !clear_status);
      odd_frame   <= frame_odd || (odd_frame && !clear_status);
    end
  end
  always_ff @(posedge if_clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {sof_pending, phase ? v : u, y};
endmodule

// File: doc/yuv422_pack.md
YUV422_PACK -- requirements
Module: yuv422_pack

Interface
REQ-001 Parameter PIXEL_WIDTH, 8: width of the y, u and v samples.
REQ-002 Parameter DTYPE_WIDTH, 5: width of the dtype field.
REQ-003 Parameter DTYPE_FRAME_START, 'h01: dtype code that opens a frame.
REQ-004 Parameter DTYPE_PIXEL, 'h02: dtype code for a pixel beat.
REQ-005 Parameter DTYPE_FRAME_END, 'h04: dtype code that closes a frame.
REQ-006 Parameter FIFO_DEPTH, 16: output FIFO depth; SHALL be a power of two, minimum 4.
REQ-007 if_clk  in  1  block clock; all logic SHALL be on its rising edge.
REQ-008 resetb  in  1  asynchronous reset, active-low.
REQ-009 enable  in  1  packing enable.
REQ-010 dvi  in  1  input beat valid.
REQ-011 dtypei  in  DTYPE_WIDTH  input beat type.
REQ-012 y  in  PIXEL_WIDTH  luma, from the gamma stage output.
REQ-013 u, v  in  PIXEL_WIDTH each  chroma samples.
REQ-014 datao  out  2*PIXEL_WIDTH  packed word, {chroma, y}.
REQ-015 sofo  out  1  marks datao as the first word of a frame.
REQ-016 dvo  out  1  datao/sofo valid (FIFO not empty).
REQ-017 rdyi  in  1  consumer ready; a word pops when dvo && rdyi.
REQ-018 level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-019 overflow  out  1  sticky flag: a pixel was dropped.
REQ-020 odd_frame  out  1  sticky flag: a frame ended with an odd pixel count.
REQ-021 clear_status  in  1  one-cycle pulse that clears overflow and odd_frame.

Function
REQ-022 The FSM SHALL have two states, IDLE and ACTIVE.
REQ-023 IDLE->ACTIVE when enable && dvi && dtypei==DTYPE_FRAME_START; at the same time phase:=0 and sof_pending:=1.
REQ-024 ACTIVE->IDLE on dvi && dtypei==DTYPE_FRAME_END, or on enable==0 (immediately, mid-frame).
REQ-025 ACTIVE with FRAME_START received: restart the frame (phase:=0, sof_pending:=1), stay ACTIVE.
REQ-026 Push condition: state ACTIVE && enable && dvi && dtypei==DTYPE_PIXEL.
REQ-027 Pixel beats in IDLE SHALL be ignored.
REQ-028 Other dtype codes SHALL be ignored in both states.
REQ-029 Push word = phase ? {v,y} : {u,y}; sofo bit = sof_pending.
REQ-030 Phase SHALL toggle on every push attempt, including dropped ones.
REQ-031 sof_pending SHALL clear on every push attempt, including dropped ones.
REQ-032 FRAME_END in ACTIVE with phase==1 SHALL set odd_frame.
REQ-033 Full SHALL be evaluated before the same-cycle pop.
REQ-034 A push when level==FIFO_DEPTH SHALL be dropped (no write, pointers unchanged) and SHALL set overflow, even if a pop occurs in that cycle.
REQ-035 The FIFO SHALL be show-ahead; datao/sofo SHALL be the head entry whenever dvo==1.
REQ-036 dvo SHALL equal (level!=0).
REQ-037 Latency: a pixel pushed into an empty FIFO at edge N SHALL give dvo=1 with its word after edge N.
REQ-038 Push and pop in the same cycle with 0<level<FIFO_DEPTH: level unchanged, order preserved.
REQ-039 A pop with level==0 SHALL be impossible (dvo==0), so pointers never underflow.
REQ-040 Pointers SHALL wrap modulo FIFO_DEPTH, using an extra MSB to distinguish full from empty.
REQ-041 Sticky-flag priority: if clear_status coincides with a set event, the flag SHALL end set.
REQ-042 Deasserting enable SHALL NOT flush the FIFO; queued words still drain.

Reset
REQ-043 resetb low SHALL asynchronously force: state IDLE, phase 0, sof_pending 0, pointers 0, level 0, dvo 0, datao 0, sofo 0, overflow 0, odd_frame 0.
REQ-044 FIFO storage need not be reset; datao SHALL read 0 while level==0.
REQ-045 After release, packing SHALL resume only at the next FRAME_START.

Verification
REQ-046 Scenario: enable=1, rdyi=1; FRAME_START, then 4 pixels (y=10,20,30,40; u=1,2,3,4; v=5,6,7,8), then FRAME_END -> datao words 'h010A(sofo=1), 'h0614, 'h031E, 'h0828; odd_frame=0.
REQ-047 Scenario: rdyi=0; FRAME_START, then 18 pixels -> level saturates at 16, overflow=1; with rdyi=1 the first 16 words drain in order.
REQ-048 Scenario: FRAME_START, 3 pixels, FRAME_END -> odd_frame=1; clear_status pulse -> odd_frame=0.
REQ-049 Scenario: pixels with no FRAME_START, or with enable=0 -> level stays 0; enable dropped mid-frame -> later pixels ignored, queued words still drain.
REQ-050 Scenario: level==16 with a simultaneous push and pop -> one word popped, push dropped, overflow=1, level=15.
REQ-051 Scenario: resetb pulsed low mid-frame with level=5 -> dvo=0, level=0 immediately; pixels ignored until the next FRAME_START.
